dl_demux4_pipe: RTL and testbench

//   Registered 1-to-4 stream demultiplexer: routes each beat of a valid/ready input

---
 rtl/dl_demux4_pipe.sv | 155 +++++++++++++++
 tb/tb_dl_demux4_pipe.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dl_demux4_pipe.sv
// Registered 1-to-4 valid/ready stream demultiplexer with one single-entry slot per output.
// Latency: exactly 1 cycle from input acceptance to out_valid; outputs come straight from slot registers.
// Backpressure: a full slot stalls the input only while in_sel points at it and its consumer is not ready.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid/in_ready        input handshake; in_sel picks the destination, in_data is the payload
//   out_valid[3:0]           per-output beat present; out_ready[3:0] per-output consumer ready
//   out0_data..out3_data     per-output payload (slot register)
//   stats_clr, cnt0..cnt3    transfer counters, present only with DL_DEMUX4_STATS_EN defined
module dl_demux4_pipe #(
    parameter int NUM_BITS = 32,
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_sel,
    input  logic [NUM_BITS-1:0] in_data,
    output logic [3:0]          out_valid,
    input  logic [3:0]          out_ready,
    output logic [NUM_BITS-1:0] out0_data,
    output logic [NUM_BITS-1:0] out1_data,
    output logic [NUM_BITS-1:0] out2_data,
    output logic [NUM_BITS-1:0] out3_data
`ifdef DL_DEMUX4_STATS_EN
    ,
    input  logic                stats_clr,
    output logic [CNT_BITS-1:0] cnt0,
    output logic [CNT_BITS-1:0] cnt1,
    output logic [CNT_BITS-1:0] cnt2,
    output logic [CNT_BITS-1:0] cnt3
`endif
);

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    slot_state_e         slot_q [4];
    slot_state_e         slot_d [4];
    logic [NUM_BITS-1:0] data_q [4];
    logic [NUM_BITS-1:0] data_d [4];
    logic [3:0]          load;
    logic [3:0]          drain;

    // A full slot can still accept when its consumer empties it this same cycle,
    // which keeps one beat per cycle flowing to a ready destination.
    // Deliberately independent of in_valid.
    always_comb begin
        in_ready = (slot_q[in_sel] == SLOT_EMPTY) | out_ready[in_sel];
    end

    always_comb begin
        load  = '0;
        drain = '0;
        for (int i = 0; i < 4; i++) begin
            load[i]  = in_valid & in_ready & (in_sel == 2'(i));
            drain[i] = (slot_q[i] == SLOT_FULL) & out_ready[i];
        end
    end

    // Next-state logic per slot
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            slot_d[i] = slot_q[i];
            data_d[i] = data_q[i];
            case (slot_q[i])
                SLOT_EMPTY: begin
                    if (load[i]) begin
                        slot_d[i] = SLOT_FULL;
                    end
                end
                SLOT_FULL: begin
                    // A simultaneous load refills the slot instead of emptying it.
                    if (drain[i] && !load[i]) begin
                        slot_d[i] = SLOT_EMPTY;
                    end
                end
                default: slot_d[i] = SLOT_EMPTY;
            endcase
            if (load[i]) begin
                data_d[i] = in_data;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                slot_q[i] <= SLOT_EMPTY;
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                slot_q[i] <= slot_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

    // Outputs come only from registered state
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            out_valid[i] = (slot_q[i] == SLOT_FULL);
        end
        out0_data = data_q[0];
        out1_data = data_q[1];
        out2_data = data_q[2];
        out3_data = data_q[3];
    end

`ifdef DL_DEMUX4_STATS_EN
    logic [CNT_BITS-1:0] cnt_q [4];
    logic [CNT_BITS-1:0] cnt_d [4];

    // drain[i] is exactly out_valid[i] & out_ready[i]; clear beats increment, count saturates.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (stats_clr) begin
                cnt_d[i] = '0;
            end else if (drain[i] && (cnt_q[i] != {CNT_BITS{1'b1}})) begin
                cnt_d[i] = cnt_q[i] + CNT_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        cnt0 = cnt_q[0];
        cnt1 = cnt_q[1];
        cnt2 = cnt_q[2];
        cnt3 = cnt_q[3];
    end
`else
    // CNT_BITS only sizes the counters; keep it referenced when they are compiled out.
    localparam int UNUSED_CNT_BITS = CNT_BITS;
`endif

endmodule

// File: tb/tb_dl_demux4_pipe.sv
module tb_dl_demux4_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_sel;
    logic [31:0] in_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out0_data, out1_data, out2_data, out3_data;
`ifdef DL_DEMUX4_STATS_EN
    logic        stats_clr;
    logic [1:0]  cnt0, cnt1, cnt2, cnt3;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dl_demux4_pipe #(.NUM_BITS(32), .CNT_BITS(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out0_data (out0_data),
        .out1_data (out1_data),
        .out2_data (out2_data),
        .out3_data (out3_data)
`ifdef DL_DEMUX4_STATS_EN
        ,
        .stats_clr (stats_clr),
        .cnt0      (cnt0),
        .cnt1      (cnt1),
        .cnt2      (cnt2),
        .cnt3      (cnt3)
`endif
    );

    logic [31:0] od [4];
    assign od[0] = out0_data;
    assign od[1] = out1_data;
    assign od[2] = out2_data;
    assign od[3] = out3_data;

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] data;
        logic [3:0]  rdy;
    } vec_t;

    vec_t        vecs [16];
    logic [31:0] sb [4][$];
    logic [3:0]  prev_vld;
    logic [3:0]  prev_rdy;
    logic [31:0] prev_dat [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Called at the negedge: compares leaving beats, checks hold-while-stalled,
    // then records the beat the input will hand over at the coming edge.
    task automatic monitor();
        for (int i = 0; i < 4; i++) begin
            if (prev_vld[i] && !prev_rdy[i]) begin
                chk($sformatf("hold_vld%0d", i), 32'(out_valid[i]), 32'd1);
                chk($sformatf("hold_dat%0d", i), od[i], prev_dat[i]);
            end
            if (out_valid[i] && out_ready[i]) begin
                if (sb[i].size() == 0) begin
                    chk($sformatf("spurious_out%0d", i), od[i], 32'hxxxxxxxx);
                end else begin
                    chk($sformatf("sb_out%0d", i), od[i], sb[i].pop_front());
                end
            end
            prev_dat[i] = od[i];
        end
        prev_vld = out_valid;
        prev_rdy = out_ready;
        if (in_valid && in_ready) begin
            sb[in_sel].push_back(in_data);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            vecs[i].sel  = 2'((i * 5 + i / 3) % 4);
            vecs[i].data = 32'hC0DE0000 + 32'(i * 32'h111);
            vecs[i].rdy  = 4'($urandom);
        end
        vecs[4].sel = vecs[3].sel;
        vecs[4].rdy = 4'b0000;
        vecs[9].sel = vecs[8].sel;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        in_data   = 32'd0;
        out_ready = 4'b0000;
`ifdef DL_DEMUX4_STATS_EN
        stats_clr = 1'b0;
`endif

        // Reset state
        tick();
        tick();
        smp();
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        for (int i = 0; i < 4; i++) chk($sformatf("rst_data%0d", i), od[i], 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        tick();
        rst_n = 1'b1;

        // Route to output 2, then a second beat to the same full slot must stall
        in_valid = 1'b1; in_sel = 2'd2; in_data = 32'hDEADBEEF; out_ready = 4'b0000;
        smp();
        chk("route_in_ready", 32'(in_ready), 32'h1);
        tick();
        in_data = 32'hCAFEF00D;
        smp();
        chk("route_out_valid", 32'(out_valid), 32'h4);
        chk("route_out2", out2_data, 32'hDEADBEEF);
        chk("route_stall", 32'(in_ready), 32'h0);
        tick();
        smp();
        chk("route_hold_vld", 32'(out_valid), 32'h4);
        chk("route_hold_out2", out2_data, 32'hDEADBEEF);
        tick();
        in_valid = 1'b0; out_ready = 4'b0100;
        tick();
        smp();
        chk("route_drained", 32'(out_valid), 32'h0);

        // Streaming through output 1 without bubbles
        tick();
        in_valid = 1'b1; in_sel = 2'd1; in_data = 32'h11; out_ready = 4'b0000;
        tick();
        out_ready = 4'b0010; in_data = 32'h55;
        for (int k = 0; k < 3; k++) begin
            smp();
            chk("stream_in_ready", 32'(in_ready), 32'h1);
            chk("stream_vld1", 32'(out_valid[1]), 32'h1);
            chk("stream_out1", out1_data, (k == 0) ? 32'h11 : 32'h55);
            tick();
        end
        in_valid = 1'b0;
        smp();
        chk("stream_last_out1", out1_data, 32'h55);
        tick();
        smp();
        chk("stream_drained", 32'(out_valid), 32'h0);

        // Stalled output 0 does not block a beat to output 3
        tick();
        in_valid = 1'b1; in_sel = 2'd0; in_data = 32'hA0; out_ready = 4'b0000;
        tick();
        in_sel = 2'd3; in_data = 32'h1234;
        smp();
        chk("iso_in_ready", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        smp();
        chk("iso_out_valid", 32'(out_valid), 32'h9);
        chk("iso_out0", out0_data, 32'hA0);
        chk("iso_out3", out3_data, 32'h1234);
        tick();
        out_ready = 4'b1111;
        tick();
        smp();
        chk("iso_drained", 32'(out_valid), 32'h0);

        // Asynchronous reset with all slots full
        tick();
        in_valid = 1'b1; out_ready = 4'b0000;
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s); in_data = 32'h100 + 32'(s);
            tick();
        end
        in_valid = 1'b0;
        smp();
        chk("full_out_valid", 32'(out_valid), 32'hF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'h0);
        for (int i = 0; i < 4; i++) chk($sformatf("arst_data%0d", i), od[i], 32'h0);
        chk("arst_in_ready", 32'(in_ready), 32'h1);
        tick();
        tick();
        rst_n = 1'b1; out_ready = 4'b1111;
        for (int k = 0; k < 2; k++) begin
            smp();
            chk("post_rst_idle", 32'(out_valid), 32'h0);
            tick();
        end

`ifdef DL_DEMUX4_STATS_EN
        // Five transfers on output 0 saturate a 2-bit counter at 3
        in_valid = 1'b1; in_sel = 2'd0; out_ready = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            in_data = 32'h200 + 32'(k);
            tick();
        end
        in_valid = 1'b0;
        tick();
        smp();
        chk("stats_sat_cnt0", 32'(cnt0), 32'h3);
        chk("stats_cnt1", 32'(cnt1), 32'h0);
        tick();
        in_valid = 1'b1; out_ready = 4'b0000;
        tick();
        in_valid = 1'b0; out_ready = 4'b0001; stats_clr = 1'b1;
        smp();
        chk("stats_clr_xfer_vld", 32'(out_valid[0]), 32'h1);
        tick();
        stats_clr = 1'b0;
        smp();
        chk("stats_clr_cnt0", 32'(cnt0), 32'h0);
        tick();
`endif

        // Table-driven traffic against the per-destination scoreboard
        prev_vld = 4'b0000;
        prev_rdy = 4'b0000;
        for (int v = 0; v < 16; v++) begin
            bit acc;
            in_valid  = 1'b1;
            in_sel    = vecs[v].sel;
            in_data   = vecs[v].data;
            out_ready = vecs[v].rdy;
            acc = 1'b0;
            for (int w = 0; w < 20 && !acc; w++) begin
                @(negedge clk);
                acc = in_ready;
                monitor();
                tick();
                if (!acc) begin
                    out_ready = 4'($urandom) | ((w >= 3) ? (4'b0001 << vecs[v].sel) : 4'b0000);
                end
            end
            if (!acc) chk($sformatf("accept_timeout_v%0d", v), 32'(acc), 32'h1);
        end
        in_valid  = 1'b0;
        out_ready = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            monitor();
            tick();
        end
        for (int i = 0; i < 4; i++) chk($sformatf("sb_empty%0d", i), 32'(sb[i].size()), 32'h0);
        smp();
        chk("final_idle", 32'(out_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
